fir_pipe_param: RTL

- Parametrised, pipelined direct-form FIR filter. Generalises the fixed 4-tap, 16-bit filter.
- Number of taps, data width, coefficient width and output width are set by parameters.
- Signed arithmetic throughout; coefficients are runtime-writable registers.
- Valid/ready handshake on input and output; the output stage applies a shift and saturates.
- Sits between the sample source and the downstream DSP or ASIC evaluation harness.

---
 rtl/fir_pipe_param.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/fir_pipe_param.sv
// -----------------------------------------------------------------------------
// fir_pipe_param
//
// Parametrised, pipelined direct-form FIR filter with signed arithmetic.
//   Stage 1: delay line shift plus one full-precision product per tap.
//   Stage 2: adder tree into ACC_W bits, arithmetic right shift by SHIFT,
//            saturation to OUT_W bits.
// Coefficients are runtime-writable registers that are cleared by reset.
//
// Optional feature (compile-time macro FIR_ROUND_EN):
//   When defined and SHIFT > 0, the stage-2 shift rounds half toward
//   +infinity instead of truncating toward -infinity.
//
// Ports:
//   clk        in   clock
//   reset      in   synchronous, active-high reset (priority over all inputs)
//   in_valid   in   data_in holds a valid sample
//   in_ready   out  filter can accept a sample (combinational)
//   data_in    in   DATA_W signed input sample
//   coef_we    in   coefficient write strobe
//   coef_addr  in   tap index for the write; 0 applies to the newest sample
//   coef_data  in   COEF_W signed coefficient value
//   out_valid  out  y holds a valid result
//   out_ready  in   downstream accepts y
//   y          out  OUT_W signed filtered output
//
// Parameter limits: NTAPS >= 2, 0 <= SHIFT < ACC_W, OUT_W <= ACC_W + 1.
// -----------------------------------------------------------------------------
module fir_pipe_param #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 8,
    parameter int NTAPS  = 4,
    parameter int OUT_W  = 16,
    parameter int SHIFT  = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [DATA_W-1:0]  data_in,
    input  logic                      coef_we,
    input  logic [$clog2(NTAPS)-1:0]  coef_addr,
    input  logic signed [COEF_W-1:0]  coef_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [OUT_W-1:0]   y
);

    localparam int ADDR_W = $clog2(NTAPS);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = PROD_W + ADDR_W;

    // Rounding constant 2^(SHIFT-1); zero whenever rounding is not in use so
    // the shift path below is shared by both builds.
`ifdef FIR_ROUND_EN
    localparam logic signed [ACC_W:0] RND_K =
        (SHIFT > 0) ? ((ACC_W+1)'(1) << ((SHIFT > 0) ? (SHIFT - 1) : 0)) : '0;
`else
    localparam logic signed [ACC_W:0] RND_K = '0;
`endif

    // Output saturation limits, expressed at the widened shift width.
    localparam logic signed [ACC_W:0] SAT_MAX =
        {{(ACC_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN =
        {{(ACC_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    logic signed [DATA_W-1:0] z_q [1:NTAPS-1];
    logic signed [DATA_W-1:0] z_d [1:NTAPS-1];
    logic signed [COEF_W-1:0] c_q [0:NTAPS-1];
    logic signed [COEF_W-1:0] c_d [0:NTAPS-1];
    logic signed [PROD_W-1:0] p_q [0:NTAPS-1];
    logic signed [PROD_W-1:0] p_d [0:NTAPS-1];
    logic                     v1_q;
    logic                     v1_d;
    logic                     out_valid_q;
    logic                     out_valid_d;
    logic signed [OUT_W-1:0]  y_q;
    logic signed [OUT_W-1:0]  y_d;

    // ---------------------------------------------------------------------
    // Combinational helpers
    // ---------------------------------------------------------------------
    logic                     en;
    logic                     accept;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W:0]    s_wide;
    logic signed [ACC_W:0]    sat;

    function automatic logic signed [PROD_W-1:0] mul(
        input logic signed [DATA_W-1:0] a,
        input logic signed [COEF_W-1:0] b
    );
        logic signed [PROD_W-1:0] a_x;
        logic signed [PROD_W-1:0] b_x;
        a_x = PROD_W'(a);
        b_x = PROD_W'(b);
        return a_x * b_x;
    endfunction

    // Handshake: a transfer happens on a clock edge where valid && ready.
    // The whole pipeline advances together whenever the output register is
    // empty or being drained (en); a held output stalls every stage, and
    // in_ready follows en combinationally so no sample is dropped or repeated.
    always_comb begin
        en       = !(out_valid_q && !out_ready);
        accept   = in_valid && en;
        in_ready = en;
    end

    // Stage 1: delay line and per-tap products. p[0] multiplies the incoming
    // sample directly; p[k] uses z[k] before the shift, i.e. x[n-k].
    always_comb begin
        z_d  = z_q;
        p_d  = p_q;
        v1_d = v1_q;
        if (accept) begin
            z_d[1] = data_in;
            for (int k = 2; k < NTAPS; k++) begin
                z_d[k] = z_q[k-1];
            end
            p_d[0] = mul(data_in, c_q[0]);
            for (int k = 1; k < NTAPS; k++) begin
                p_d[k] = mul(z_q[k], c_q[k]);
            end
            v1_d = 1'b1;
        end else if (en) begin
            v1_d = 1'b0;
        end
    end

    // Stage 2: sum, shift, saturate.
    always_comb begin
        acc = '0;
        for (int k = 0; k < NTAPS; k++) begin
            acc = acc + ACC_W'(p_q[k]);
        end

        // One extra bit so adding the rounding constant cannot overflow.
        s_wide = ((ACC_W+1)'(acc) + RND_K) >>> SHIFT;

        if (s_wide > SAT_MAX) begin
            sat = SAT_MAX;
        end else if (s_wide < SAT_MIN) begin
            sat = SAT_MIN;
        end else begin
            sat = s_wide;
        end

        y_d         = y_q;
        out_valid_d = out_valid_q;
        if (en) begin
            y_d         = OUT_W'(sat);
            out_valid_d = v1_q;
        end
    end

    // Coefficient writes are independent of the pipeline enable. Because the
    // products read c_q, a sample accepted on the write edge sees the old value.
    always_comb begin
        c_d = c_q;
        if (coef_we && (32'(coef_addr) < 32'(NTAPS))) begin
            c_d[coef_addr] = coef_data;
        end
    end

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 1; k < NTAPS; k++) begin
                z_q[k] <= '0;
            end
            for (int k = 0; k < NTAPS; k++) begin
                c_q[k] <= '0;
                p_q[k] <= '0;
            end
            v1_q        <= 1'b0;
            out_valid_q <= 1'b0;
            y_q         <= '0;
        end else begin
            z_q         <= z_d;
            c_q         <= c_d;
            p_q         <= p_d;
            v1_q        <= v1_d;
            out_valid_q <= out_valid_d;
            y_q         <= y_d;
        end
    end

    assign out_valid = out_valid_q;
    assign y         = y_q;

endmodule
